img_mem_loader: RTL and testbench

- Writer side of the image block memory. The convolution pipeline reads this memory through its 13-bit address and 8-bit pixel port; this block fills it.
- Accepts a raster-order pixel stream over a valid/ready handshake and converts it into BRAM write strobes. It generates row/column addressing with a configurable base and row stride.
- Checks frame framing: exactly IMG_W*IMG_H pixels, with s_last on the final pixel.
- Signals frame_valid so the controller can release the CNN datapath.

---
 rtl/img_mem_loader.sv | 131 +++++++++++++
 tb/tb_img_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_loader.sv
// img_mem_loader: raster pixel stream to BRAM write port with frame framing checks.
// Define IMG_LOADER_CKSUM_EN to add a modulo-2^16 frame checksum output (cksum_o).
module img_mem_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 13,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int ROW_STRIDE = 64,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              hold_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              frame_valid_o,
    output logic              err_early_o,
    output logic              err_nolast_o
`ifdef IMG_LOADER_CKSUM_EN
    ,
    output logic [15:0]       cksum_o
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d, rbase_q, rbase_d, addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, fv_q, fv_d, ee_q, ee_d, nl_q, nl_d;
    logic              xfer, last_px, col_wrap, clear;

    // handshake, raster counters (row base kept incrementally, no multiplier), framing and next state
    always_comb begin
        s_ready_o = state_q == LOAD && !hold_i && !abort_i;
        xfer      = s_valid_i && s_ready_o;
        col_wrap  = col_q == COL_LAST;
        last_px   = col_wrap && row_q == ROW_LAST;
        clear     = abort_i || (start_i && (state_q == IDLE || state_q == ERR));
        col_d     = xfer ? (col_wrap ? '0 : col_q + ADDR_W'(1)) : col_q;
        row_d     = xfer && col_wrap ? row_q + ADDR_W'(1) : row_q;
        rbase_d   = xfer && col_wrap ? rbase_q + STRIDE : rbase_q;
        addr_d    = xfer ? rbase_q + col_q : addr_q;
        din_d     = xfer ? s_data_i : din_q;
        fv_d      = fv_q || state_q == DONE;
        ee_d      = ee_q || (xfer && s_last_i && !last_px);
        nl_d      = nl_q || (xfer && !s_last_i && last_px);
        state_d   = state_q;
        if (abort_i)
            state_d = IDLE;
        else if (clear)
            state_d = LOAD;
        else if (state_q == DONE)
            state_d = IDLE;
        else if (xfer && (s_last_i || last_px))
            state_d = s_last_i && last_px ? DONE : ERR;
        if (clear) begin
            col_d   = '0;
            row_d   = '0;
            rbase_d = BASE;
            fv_d    = 1'b0;
            ee_d    = 1'b0;
            nl_d    = 1'b0;
        end
    end

    // state, counters, status flags and the one-cycle-latency write port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            rbase_q <= BASE;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            fv_q    <= 1'b0;
            ee_q    <= 1'b0;
            nl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rbase_q <= rbase_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= xfer;
            fv_q    <= fv_d;
            ee_q    <= ee_d;
            nl_q    <= nl_d;
        end
    end

    assign mem_en_o      = wr_q;
    assign mem_we_o      = wr_q;
    assign mem_addr_o    = addr_q;
    assign mem_din_o     = din_q;
    assign busy_o        = state_q == LOAD;
    assign load_done_o   = state_q == DONE;
    assign frame_valid_o = fv_q;
    assign err_early_o   = ee_q;
    assign err_nolast_o  = nl_q;

`ifdef IMG_LOADER_CKSUM_EN
    logic [15:0] cksum_q;

    // running sum of accepted pixels; frozen once the frame has ended
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cksum_q <= '0;
        else
            cksum_q <= clear ? '0 : xfer ? cksum_q + 16'(s_data_i) : cksum_q;
    end

    assign cksum_o = cksum_q;
`endif
endmodule

// File: tb/tb_img_mem_loader.sv
// tb_img_mem_loader: scoreboard bench for img_mem_loader; a second instance uses BASE_ADDR=100, ROW_STRIDE=72.
module tb_img_mem_loader;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, hold = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, mem_en, mem_we, busy, load_done, frame_valid, err_early, err_nolast;
    logic [12:0] mem_addr;
    logic [7:0]  mem_din;
    logic        s_ready2, mem_en2, mem_we2, busy2, load_done2, frame_valid2, err_early2, err_nolast2;
    logic [12:0] mem_addr2;
    logic [7:0]  mem_din2;
`ifdef IMG_LOADER_CKSUM_EN
    logic [15:0] cksum, cksum2;
`endif

    int errors = 0, checks = 0, ld_cnt = 0, wr_cnt = 0;

    typedef struct {logic [12:0] a; logic [7:0] d;} wr_t;
    wr_t q1[$], q2[$];
    wr_t e1, e2;

    img_mem_loader dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .hold_i(hold),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
        .busy_o(busy), .load_done_o(load_done), .frame_valid_o(frame_valid),
        .err_early_o(err_early), .err_nolast_o(err_nolast)
`ifdef IMG_LOADER_CKSUM_EN
        , .cksum_o(cksum)
`endif
    );

    img_mem_loader #(.ROW_STRIDE(72), .BASE_ADDR(100)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .hold_i(hold),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready2),
        .mem_en_o(mem_en2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_din_o(mem_din2),
        .busy_o(busy2), .load_done_o(load_done2), .frame_valid_o(frame_valid2),
        .err_early_o(err_early2), .err_nolast_o(err_nolast2)
`ifdef IMG_LOADER_CKSUM_EN
        , .cksum_o(cksum2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // monitor: every presented write is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n) begin
            ld_cnt += int'(load_done);
            if (mem_en || mem_we) begin
                chk("mem_en==mem_we", 32'(mem_en), 32'(mem_we));
                if (q1.size() == 0)
                    chk("unexpected write addr", 32'(mem_addr), 32'hFFFF_FFFF);
                else begin
                    e1 = q1.pop_front();
                    wr_cnt++;
                    chk("write addr", 32'(mem_addr), 32'(e1.a));
                    chk("write data", 32'(mem_din), 32'(e1.d));
                end
            end
            if (mem_en2 || mem_we2) begin
                if (q2.size() == 0)
                    chk("unexpected stride write addr", 32'(mem_addr2), 32'hFFFF_FFFF);
                else begin
                    e2 = q2.pop_front();
                    chk("stride write addr", 32'(mem_addr2), 32'(e2.a));
                    chk("stride write data", 32'(mem_din2), 32'(e2.d));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        s_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // drive pixel n for one cycle; exp_x says whether the bench expects it to be accepted
    task automatic beat(input int n, input bit last, input bit hld, input bit exp_x);
        s_valid = 1'b1;
        s_data  = 8'(n);
        s_last  = last;
        hold    = hld;
        if (exp_x) begin
            q1.push_back('{13'(n), 8'(n)});
            q2.push_back('{13'(100 + (n / 64) * 72 + n % 64), 8'(n)});
        end
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(exp_x));
        step();
    endtask

    task automatic abort_cycle(input bit st);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        s_last  = 1'b0;
        hold    = 1'b0;
        abort   = 1'b1;
        start   = st;
        @(negedge clk);
        chk("s_ready in abort cycle", 32'(s_ready), 0);
        step();
        abort   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        chk("busy after abort", 32'(busy), 0);
        chk("no write after abort", 32'(mem_we), 0);
        step();
        chk("idle after abort", 32'({busy, frame_valid, err_early, err_nolast}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        bit h;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({s_ready, mem_en, mem_we, mem_addr, mem_din, busy, load_done,
            frame_valid, err_early, err_nolast}), 0);
        chk("reset outputs stride", 32'({s_ready2, mem_we2, mem_addr2, busy2, frame_valid2}), 0);
        step();
        rst_n = 1'b1;
        step();
        s_valid = 1'b1;
        @(negedge clk);
        chk("idle s_ready", 32'(s_ready), 0);
        chk("idle busy", 32'(busy), 0);
        step();

        // full frame
        wr_cnt = 0;
        pulse_start();
        chk("busy after start", 32'(busy), 1);
        for (int n = 0; n < 4096; n++) beat(n, n == 4095, 1'b0, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("load_done with last write", 32'({load_done, mem_we, mem_addr}), 32'({1'b1, 1'b1, 13'd4095}));
        chk("stride last addr", 32'(mem_addr2), 4699);
        chk("frame_valid before done", 32'(frame_valid), 0);
        step();
        chk("load_done one cycle", 32'(load_done), 0);
        chk("frame_valid", 32'(frame_valid), 1);
        chk("busy after frame", 32'(busy), 0);
        chk("writes in frame", 32'(wr_cnt), 4096);
        chk("no errors", 32'({err_early, err_nolast}), 0);
`ifdef IMG_LOADER_CKSUM_EN
        chk("cksum", 32'(cksum), 32'hF800);
        chk("cksum stride", 32'(cksum2), 32'hF800);
`endif

        // back-pressure: hold during load cycles 10..19
        pulse_start();
        chk("frame_valid cleared by start", 32'(frame_valid), 0);
        p = 0;
        for (int k = 0; k < 30; k++) begin
            h = k >= 10 && k < 20;
            beat(p, 1'b0, h, !h);
            if (h) chk("no write under hold", 32'(mem_we), 0);
            else p++;
        end
        chk("pixels through hold", 32'(p), 20);
        abort_cycle(1'b0);

        // early last on pixel 100
        pulse_start();
        for (int n = 0; n < 100; n++) beat(n, 1'b0, 1'b0, 1'b1);
        beat(100, 1'b1, 1'b0, 1'b1);
        chk("err_early", 32'({err_early, err_nolast, frame_valid, busy, load_done}), 32'(5'b10000));
        @(negedge clk);
        chk("ERR s_ready", 32'(s_ready), 0);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("err_early held", 32'(err_early), 1);
        abort_cycle(1'b0);

        // final pixel without s_last
        pulse_start();
        for (int n = 0; n < 4096; n++) beat(n, 1'b0, 1'b0, 1'b1);
        s_valid = 1'b0;
        chk("err_nolast", 32'({err_nolast, err_early, load_done, frame_valid}), 32'(4'b1000));
        step();
        chk("err_nolast held", 32'({err_nolast, busy}), 32'(2'b10));
        pulse_start();
        chk("restart clears flags", 32'({err_nolast, err_early, busy}), 32'(3'b001));
        for (int n = 0; n < 10; n++) beat(n, 1'b0, 1'b0, 1'b1);
        abort_cycle(1'b0);

        // abort together with start at pixel 2000
        pulse_start();
        for (int n = 0; n < 2000; n++) beat(n, 1'b0, 1'b0, 1'b1);
        abort_cycle(1'b1);

        // reload from address 0, then reset at pixel 500
        pulse_start();
        for (int n = 0; n < 500; n++) beat(n, 1'b0, 1'b0, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'(500);
        #1 rst_n = 1'b0;
        #1;
        chk("outputs in mid-frame reset", 32'({s_ready, mem_en, mem_we, mem_addr, mem_din, busy,
            load_done, frame_valid, err_early, err_nolast}), 0);
        chk("stride outputs in reset", 32'({s_ready2, mem_we2, mem_addr2, busy2}), 0);
        q1.delete();
        q2.delete();
        step();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        step();
        chk("idle after reset", 32'({busy, frame_valid, mem_we}), 0);

        chk("load_done pulses", 32'(ld_cnt), 1);
        chk("scoreboard drained", 32'(q1.size() + q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
